// File: rtl/timer_seq_ctrl_if.sv
// Segment-table configuration bus for timer_seq_ctrl.
// master drives a write (CFG_WE, CFG_IDX, CFG_MODE, CFG_TOT, CFG_DUTY, CFG_REP), slave receives it.
interface timer_seq_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             CFG_WE;
   logic [1:0]       CFG_IDX;
   logic             CFG_MODE;
   logic [CNT_W-1:0] CFG_TOT;
   logic [CNT_W-1:0] CFG_DUTY;
   logic [7:0]       CFG_REP;

   modport master (
      output CFG_WE, CFG_IDX, CFG_MODE,
      output CFG_TOT, CFG_DUTY, CFG_REP
   );

   modport slave (
      input CFG_WE, CFG_IDX, CFG_MODE,
      input CFG_TOT, CFG_DUTY, CFG_REP
   );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Sequences a PWM-style timer through a 4-entry table of {MODE,TOT,DUTY,REP} segments.
// Ports: PCLK/PRESETn, cfg (table write bus), NUM_SEG/LOOP/START/STOP/IRQ_TRG in;
// MODE/GO_EN/TOT_CNT/DUTY_CNT/BUSY/SEG_IDX/DONE out, all registered.
module timer_seq_ctrl #(
   parameter int CNT_W = 32,
   parameter int NSEG  = 4
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   timer_seq_ctrl_if.slave    cfg,
   input  logic [1:0]         NUM_SEG,
   input  logic               LOOP,
   input  logic               START,
   input  logic               STOP,
   input  logic               IRQ_TRG,
   output logic               MODE,
   output logic               GO_EN,
   output logic [CNT_W-1:0]   TOT_CNT,
   output logic [CNT_W-1:0]   DUTY_CNT,
   output logic               BUSY,
   output logic [1:0]         SEG_IDX,
   output logic               DONE
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       seg_q, seg_d;
   logic [7:0]       rep_q, rep_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] tot_q, tot_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic             go_en_q, go_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             tbl_mode_q [NSEG];
   logic             tbl_mode_d [NSEG];
   logic [CNT_W-1:0] tbl_tot_q  [NSEG];
   logic [CNT_W-1:0] tbl_tot_d  [NSEG];
   logic [CNT_W-1:0] tbl_duty_q [NSEG];
   logic [CNT_W-1:0] tbl_duty_d [NSEG];
   logic [7:0]       tbl_rep_q  [NSEG];
   logic [7:0]       tbl_rep_d  [NSEG];

   logic             load;

   always_comb begin
      tbl_mode_d = tbl_mode_q;
      tbl_tot_d  = tbl_tot_q;
      tbl_duty_d = tbl_duty_q;
      tbl_rep_d  = tbl_rep_q;
      // The table is frozen while a sequence is active.
      if (cfg.CFG_WE && !busy_q) begin
         tbl_mode_d[cfg.CFG_IDX] = cfg.CFG_MODE;
         tbl_tot_d[cfg.CFG_IDX]  = cfg.CFG_TOT;
         tbl_duty_d[cfg.CFG_IDX] = cfg.CFG_DUTY;
         tbl_rep_d[cfg.CFG_IDX]  = cfg.CFG_REP;
      end
   end

   always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      rep_d   = rep_q;
      load    = 1'b0;
      if (STOP) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  state_d = S_LOAD;
                  seg_d   = 2'd0;
                  load    = 1'b1;
               end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
               if (IRQ_TRG) begin
                  if (rep_q != 8'd0) begin
                     rep_d = rep_q - 8'd1;
                  end else if (seg_q < NUM_SEG) begin
                     seg_d   = seg_q + 2'd1;
                     state_d = S_LOAD;
                     load    = 1'b1;
                  end else if (LOOP) begin
                     seg_d   = 2'd0;
                     state_d = S_LOAD;
                     load    = 1'b1;
                  end else begin
                     state_d = S_FIN;
                  end
               end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // Segment values are captured on entry to LOAD so they are
      // already stable while GO_EN is low for the timer restart.
      mode_d = mode_q;
      tot_d  = tot_q;
      duty_d = duty_q;
      if (load) begin
         mode_d = tbl_mode_q[seg_d];
         tot_d  = tbl_tot_q[seg_d];
         duty_d = tbl_duty_q[seg_d];
         rep_d  = tbl_rep_q[seg_d];
      end

      go_en_d = (state_d == S_RUN);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_FIN);
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
         seg_q   <= 2'd0;
         rep_q   <= 8'd0;
         mode_q  <= 1'b0;
         tot_q   <= '0;
         duty_q  <= '0;
         go_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NSEG; i++) begin
            tbl_mode_q[i] <= 1'b0;
            tbl_tot_q[i]  <= '0;
            tbl_duty_q[i] <= '0;
            tbl_rep_q[i]  <= 8'd0;
         end
      end else begin
         state_q    <= state_d;
         seg_q      <= seg_d;
         rep_q      <= rep_d;
         mode_q     <= mode_d;
         tot_q      <= tot_d;
         duty_q     <= duty_d;
         go_en_q    <= go_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tbl_mode_q <= tbl_mode_d;
         tbl_tot_q  <= tbl_tot_d;
         tbl_duty_q <= tbl_duty_d;
         tbl_rep_q  <= tbl_rep_d;
      end
   end

   assign MODE     = mode_q;
   assign GO_EN    = go_en_q;
   assign TOT_CNT  = tot_q;
   assign DUTY_CNT = duty_q;
   assign BUSY     = busy_q;
   assign SEG_IDX  = seg_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed self-checking bench for timer_seq_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_timer_seq_ctrl;
   localparam int CNT_W = 32;

   logic             PCLK = 1'b0;
   logic             PRESETn;
   logic [1:0]       NUM_SEG;
   logic             LOOP, START, STOP, IRQ_TRG;
   logic             MODE, GO_EN, BUSY, DONE;
   logic [CNT_W-1:0] TOT_CNT, DUTY_CNT;
   logic [1:0]       SEG_IDX;

   int n_chk = 0;
   int n_err = 0;

   timer_seq_ctrl_if #(.CNT_W(CNT_W)) cfg ();

   timer_seq_ctrl #(.CNT_W(CNT_W), .NSEG(4)) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .cfg      (cfg.slave),
      .NUM_SEG  (NUM_SEG),
      .LOOP     (LOOP),
      .START    (START),
      .STOP     (STOP),
      .IRQ_TRG  (IRQ_TRG),
      .MODE     (MODE),
      .GO_EN    (GO_EN),
      .TOT_CNT  (TOT_CNT),
      .DUTY_CNT (DUTY_CNT),
      .BUSY     (BUSY),
      .SEG_IDX  (SEG_IDX),
      .DONE     (DONE)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic cfg_wr(input logic [1:0] idx, input logic m,
                         input logic [31:0] tot, input logic [31:0] duty,
                         input logic [7:0] rep);
      cfg.CFG_WE   = 1'b1;
      cfg.CFG_IDX  = idx;
      cfg.CFG_MODE = m;
      cfg.CFG_TOT  = tot;
      cfg.CFG_DUTY = duty;
      cfg.CFG_REP  = rep;
      tick();
      cfg.CFG_WE = 1'b0;
   endtask

   task automatic start_pulse();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic irq_pulse();
      IRQ_TRG = 1'b1;
      tick();
      IRQ_TRG = 1'b0;
   endtask

   task automatic stat(input string tag, input logic go,
                       input logic bsy, input logic dn,
                       input logic [1:0] seg);
      chk({tag, ".go"},   GO_EN, go);
      chk({tag, ".busy"}, BUSY, bsy);
      chk({tag, ".done"}, DONE, dn);
      chk({tag, ".seg"},  SEG_IDX, seg);
   endtask

   task automatic vals(input string tag, input logic m,
                       input logic [31:0] tot, input logic [31:0] duty);
      chk({tag, ".mode"}, MODE, m);
      chk({tag, ".tot"},  TOT_CNT, tot);
      chk({tag, ".duty"}, DUTY_CNT, duty);
   endtask

   initial begin
      PRESETn = 1'b0;
      NUM_SEG = 2'd0;
      LOOP = 1'b0; START = 1'b0; STOP = 1'b0; IRQ_TRG = 1'b0;
      cfg.CFG_WE = 1'b0; cfg.CFG_IDX = 2'd0; cfg.CFG_MODE = 1'b0;
      cfg.CFG_TOT = '0; cfg.CFG_DUTY = '0; cfg.CFG_REP = 8'd0;
      tick(); tick();
      PRESETn = 1'b1;
      stat("rst", 0, 0, 0, 2'd0);
      vals("rst", 0, 0, 0);

      // Single segment, 3 periods
      cfg_wr(2'd0, 1'b1, 32'd100, 32'd25, 8'd2);
      start_pulse();
      stat("s1.load", 0, 1, 0, 2'd0);
      tick();
      stat("s1.run", 1, 1, 0, 2'd0);
      vals("s1.run", 1, 100, 25);
      irq_pulse();
      stat("s1.irq1", 1, 1, 0, 2'd0);
      irq_pulse();
      stat("s1.irq2", 1, 1, 0, 2'd0);
      irq_pulse();
      stat("s1.fin", 0, 1, 1, 2'd0);
      tick();
      stat("s1.idle", 0, 0, 0, 2'd0);
      vals("s1.hold", 1, 100, 25);

      // STOP with START in IDLE stays idle
      STOP = 1'b1;
      start_pulse();
      STOP = 1'b0;
      stat("ss.idle", 0, 0, 0, 2'd0);

      // Multi-segment, REP=0 each
      cfg_wr(2'd0, 1'b0, 32'd10, 32'd1, 8'd0);
      cfg_wr(2'd1, 1'b1, 32'd20, 32'd2, 8'd0);
      cfg_wr(2'd2, 1'b0, 32'd30, 32'd3, 8'd0);
      NUM_SEG = 2'd2;
      start_pulse();
      tick();
      stat("m.run0", 1, 1, 0, 2'd0);
      vals("m.run0", 0, 10, 1);
      irq_pulse();
      stat("m.load1", 0, 1, 0, 2'd1);
      tick();
      stat("m.run1", 1, 1, 0, 2'd1);
      vals("m.run1", 1, 20, 2);
      irq_pulse();
      stat("m.load2", 0, 1, 0, 2'd2);
      tick();
      vals("m.run2", 0, 30, 3);
      irq_pulse();
      stat("m.fin", 0, 1, 1, 2'd2);
      tick();
      stat("m.idle", 0, 0, 0, 2'd2);

      // Loop over segments 0,1 then clear LOOP
      NUM_SEG = 2'd1;
      LOOP = 1'b1;
      start_pulse();
      tick();
      stat("l.run0", 1, 1, 0, 2'd0);
      irq_pulse();
      tick();
      stat("l.run1", 1, 1, 0, 2'd1);
      irq_pulse();
      stat("l.wrap", 0, 1, 0, 2'd0);
      tick();
      stat("l.run0b", 1, 1, 0, 2'd0);
      irq_pulse();
      tick();
      stat("l.run1b", 1, 1, 0, 2'd1);
      LOOP = 1'b0;
      irq_pulse();
      stat("l.fin", 0, 1, 1, 2'd1);
      tick();
      stat("l.idle", 0, 0, 0, 2'd1);

      // Abort: STOP wins over IRQ_TRG
      NUM_SEG = 2'd0;
      cfg_wr(2'd0, 1'b1, 32'd50, 32'd5, 8'd2);
      start_pulse();
      tick();
      irq_pulse();
      chk("ab.rep1", dut.rep_q, 8'd1);
      STOP = 1'b1;
      irq_pulse();
      STOP = 1'b0;
      stat("ab.idle", 0, 0, 0, 2'd0);
      chk("ab.rep", dut.rep_q, 8'd1);
      tick();
      chk("ab.nodone", DONE, 1'b0);

      // Write guard
      start_pulse();
      tick();
      cfg_wr(2'd0, 1'b0, 32'd7, 32'd7, 8'd0);
      STOP = 1'b1; tick(); STOP = 1'b0;
      start_pulse();
      tick();
      vals("wg.busy", 1, 50, 5);
      STOP = 1'b1; tick(); STOP = 1'b0;
      cfg_wr(2'd0, 1'b0, 32'd7, 32'd3, 8'd0);
      start_pulse();
      tick();
      stat("wg.run", 1, 1, 0, 2'd0);
      vals("wg.idle", 0, 7, 3);

      // Mid-run reset clears outputs and table
      PRESETn = 1'b0;
      tick();
      PRESETn = 1'b1;
      stat("mr.rst", 0, 0, 0, 2'd0);
      vals("mr.rst", 0, 0, 0);
      start_pulse();
      tick();
      stat("mr.run", 1, 1, 0, 2'd0);
      vals("mr.tbl", 0, 0, 0);
      irq_pulse();
      stat("mr.fin", 0, 1, 1, 2'd0);
      tick();
      stat("mr.idle", 0, 0, 0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
